// File: rtl/sr_cmd_debouncer.sv
// Command front-end for an SR flip-flop. Two raw request lines are synchronised and debounced.
// Each qualified press becomes a single, mutually exclusive s/r pulse.

module sr_cmd_deb_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 1 is the accepted level, bit 0 marks a pending change.
  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    ST_CHK_HI = 2'b01,
    ST_HIGH   = 2'b10,
    ST_CHK_LO = 2'b11
  } state_e;

  logic          sync_s1_q;
  logic          sync_s2_q;
  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise_s;

  // Two-flop synchroniser; the raw pin feeds the first flop directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_s1_q <= 1'b0;
      sync_s2_q <= 1'b0;
    end else begin
      sync_s1_q <= raw_i;
      sync_s2_q <= sync_s1_q;
    end
  end

  // Debounce state and stability counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOW;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a change is accepted after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_s  = 1'b0;
    case (state_q)
      ST_LOW, ST_CHK_HI: begin
        if (!sync_s2_q) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
          rise_s  = 1'b1;
        end else begin
          state_d = ST_CHK_HI;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH, ST_CHK_LO: begin
        if (sync_s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_CHK_LO;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign lvl_o  = state_q[1];
  assign rise_o = rise_s;

endmodule

module sr_cmd_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          SET_PRIORITY    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_in,
  input  logic clr_in,
  input  logic en,
  output logic s,
  output logic r,
  output logic set_lvl,
  output logic clr_lvl,
  output logic conflict
);

  logic rise_set_s;
  logic rise_clr_s;
  logic s_q;
  logic s_d;
  logic r_q;
  logic r_d;
  logic conflict_q;
  logic conflict_d;

  sr_cmd_deb_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_chan (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (set_in),
    .lvl_o  (set_lvl),
    .rise_o (rise_set_s)
  );

  sr_cmd_deb_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_chan (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (clr_in),
    .lvl_o  (clr_lvl),
    .rise_o (rise_clr_s)
  );

  // Pulse arbitration: on a simultaneous rise only the priority side fires, the other is dropped.
  always_comb begin
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    if (en) begin
      conflict_d = rise_set_s & rise_clr_s;
      if (rise_set_s && rise_clr_s) begin
        s_d = SET_PRIORITY;
        r_d = ~SET_PRIORITY;
      end else begin
        s_d = rise_set_s;
        r_d = rise_clr_s;
      end
    end else begin
      s_d        = 1'b0;
      r_d        = 1'b0;
      conflict_d = 1'b0;
    end
  end

  // Registered pulse outputs, aligned with the level update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Self-checking bench for sr_cmd_debouncer: window-based reference model compared every cycle,
// plus directed scenarios with hand-computed latencies, run on SET_PRIORITY=1 and =0 instances.

module tb_sr_cmd_debouncer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n, set_in, clr_in, en;
  logic s, r, set_lvl, clr_lvl, conflict;
  logic s0, r0, set_lvl0, clr_lvl0, conflict0;

  int checks = 0;
  int errors = 0;
  int n_s, n_r, n_s0;

  // Reference model: accepted level flips once the last D synced samples all differ from it.
  bit raw_hist[2][$];
  bit sync_hist[2][$];
  bit m_lvl[2];
  bit m_s, m_r, m_conf, m_s0, m_r0, m_conf0;

  sr_cmd_debouncer #(.DEBOUNCE_CYCLES(D), .SET_PRIORITY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .set_in(set_in), .clr_in(clr_in), .en(en),
    .s(s), .r(r), .set_lvl(set_lvl), .clr_lvl(clr_lvl), .conflict(conflict)
  );

  sr_cmd_debouncer #(.DEBOUNCE_CYCLES(D), .SET_PRIORITY(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .set_in(set_in), .clr_in(clr_in), .en(en),
    .s(s0), .r(r0), .set_lvl(set_lvl0), .clr_lvl(clr_lvl0), .conflict(conflict0)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int ch = 0; ch < 2; ch++) begin
      raw_hist[ch].delete();
      sync_hist[ch].delete();
      m_lvl[ch] = 1'b0;
    end
    m_s = 1'b0; m_r = 1'b0; m_conf = 1'b0;
    m_s0 = 1'b0; m_r0 = 1'b0; m_conf0 = 1'b0;
  endtask

  task automatic model_edge();
    bit raw, s2, acc;
    bit rise[2];
    for (int ch = 0; ch < 2; ch++) begin
      raw = (ch == 0) ? set_in : clr_in;
      s2 = (raw_hist[ch].size() == 2) ? raw_hist[ch][0] : 1'b0;
      raw_hist[ch].push_back(raw);
      if (raw_hist[ch].size() > 2) void'(raw_hist[ch].pop_front());
      sync_hist[ch].push_back(s2);
      if (sync_hist[ch].size() > D) void'(sync_hist[ch].pop_front());
      acc = (sync_hist[ch].size() == D);
      for (int i = 0; i < sync_hist[ch].size(); i++)
        if (sync_hist[ch][i] == m_lvl[ch]) acc = 1'b0;
      rise[ch] = acc && !m_lvl[ch];
      if (acc) begin
        m_lvl[ch] = !m_lvl[ch];
        sync_hist[ch].delete();
      end
    end
    m_conf  = en && rise[0] && rise[1];
    m_s     = en && rise[0];
    m_r     = en && rise[1] && !rise[0];
    m_conf0 = m_conf;
    m_s0    = en && rise[0] && !rise[1];
    m_r0    = en && rise[1];
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #2;
    n_s  = n_s + int'(s);
    n_r  = n_r + int'(r);
    n_s0 = n_s0 + int'(s0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_s = 0; n_r = 0; n_s0 = 0;
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [9:0] act_v, exp_v;
    act_v = {s, r, set_lvl, clr_lvl, conflict, s0, r0, set_lvl0, clr_lvl0, conflict0};
    exp_v = {m_s, m_r, m_lvl[0], m_lvl[1], m_conf, m_s0, m_r0, m_lvl[0], m_lvl[1], m_conf0};
    checks = checks + 1;
    if (act_v !== exp_v) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t actual %b required %b", $time, act_v, exp_v);
    end
    checks = checks + 1;
    if ((s & r) !== 1'b0 || (s0 & r0) !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mutex t=%0t actual s/r=%b%b s0/r0=%b%b required no overlap", $time, s, r, s0, r0);
    end
  end

  initial begin
    bit pat[5];
    int hs, hc;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset_n = 1'b0; set_in = 1'b0; clr_in = 1'b0; en = 1'b1;
    model_clear();
    clr_counts();
    tick_n(2);
    check("reset_outs", int'({s, r, set_lvl, clr_lvl, conflict}), 0);
    reset_n = 1'b1;
    tick_n(4);

    // Clean press: pulse lands 5 edges after the first sampling edge.
    clr_counts();
    set_in = 1'b1;
    tick_n(5);
    check("t1_s_early", int'(s), 0);
    tick();
    check("t1_s_pulse", int'(s), 1);
    check("t1_set_lvl", int'(set_lvl), 1);
    check("t1_model_s", int'(m_s), 1);
    tick();
    check("t1_s_width", int'(s), 0);
    check("t1_lvl_hold", int'(set_lvl), 1);
    tick_n(13);
    check("t1_s_count", n_s, 1);
    check("t1_r_count", n_r, 0);
    set_in = 1'b0;
    tick_n(10);
    check("t1_release_lvl", int'(set_lvl), 0);
    check("t1_release_nopulse", n_s, 1);

    // Bounce: final steady 1 sampled at edge 5, pulse at edge 10.
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      clr_in = pat[i];
      tick();
    end
    clr_in = 1'b1;
    tick_n(5);
    check("t2_r_early", n_r, 0);
    tick();
    check("t2_r_pulse", int'(r), 1);
    check("t2_clr_lvl", int'(clr_lvl), 1);
    tick_n(10);
    check("t2_r_count", n_r, 1);
    check("t2_s_count", n_s, 0);
    clr_in = 1'b0;
    tick_n(10);

    // Collision on both priority settings.
    set_in = 1'b1; clr_in = 1'b1;
    tick_n(6);
    check("t3_s", int'(s), 1);
    check("t3_r", int'(r), 0);
    check("t3_conflict", int'(conflict), 1);
    check("t3_lvls", int'({set_lvl, clr_lvl}), 3);
    check("t3_p0_s", int'(s0), 0);
    check("t3_p0_r", int'(r0), 1);
    check("t3_p0_conflict", int'(conflict0), 1);
    check("t3_p0_lvls", int'({set_lvl0, clr_lvl0}), 3);
    check("t3_model_conf", int'(m_conf), 1);
    set_in = 1'b0; clr_in = 1'b0;
    tick_n(10);

    // Reset mid-debounce with set_in held: counter at 2 when reset hits.
    clr_counts();
    set_in = 1'b1;
    tick_n(4);
    reset_n = 1'b0;
    model_clear();
    #1;
    check("t4_rst_outs", int'({s, r, set_lvl, clr_lvl, conflict}), 0);
    #1;
    tick();
    check("t4_rst_hold", int'({s, r, set_lvl, clr_lvl, conflict}), 0);
    reset_n = 1'b1;
    tick_n(5);
    check("t4_s_early", n_s, 0);
    tick();
    check("t4_s_pulse", int'(s), 1);
    tick_n(10);
    check("t4_s_count", n_s, 1);
    set_in = 1'b0;
    tick_n(10);

    // Enable gating: a rise while en=0 is lost for good.
    clr_counts();
    en = 1'b0;
    clr_in = 1'b1;
    tick_n(10);
    en = 1'b1;
    tick_n(10);
    check("t5_r_count", n_r, 0);
    check("t5_clr_lvl", int'(clr_lvl), 1);
    clr_in = 1'b0;
    tick_n(10);

    // Random soak with held intervals so real presses and bounces both occur.
    clr_counts();
    hs = 0; hc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (hs == 0) begin
        set_in = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 8);
      end
      if (hc == 0) begin
        clr_in = 1'($urandom_range(0, 1));
        hc = $urandom_range(1, 8);
      end
      en = ($urandom_range(0, 9) != 0);
      hs = hs - 1;
      hc = hc - 1;
      tick();
    end
    check("t6_some_pulses", int'(n_s > 0 && n_r > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
